// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : apb_master_bridge
//  Purpose  : APB initiator. Turns a valid/ready command port into APB
//             SETUP/ACCESS bus cycles and returns a one-cycle response with
//             read data, or an error when the slave stalls for too long.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1    clock, all logic on posedge
//    rst        in   1    asynchronous reset, active low (0 = in reset)
//    cmd_valid  in   1    command request
//    cmd_ready  out  1    command accepted on cmd_valid & cmd_ready
//    cmd_write  in   1    1 = write, 0 = read
//    cmd_addr   in   AW   target address
//    cmd_wdata  in   DW   write data
//    rsp_valid  out  1    one-cycle pulse: transfer finished
//    rsp_err    out  1    qualifies rsp_valid: 1 = wait-state timeout
//    rsp_rdata  out  DW   read data, valid with rsp_valid
//    sel        out  1    APB select
//    enable     out  1    APB enable (ACCESS phase)
//    w_en       out  1    APB write strobe
//    add        out  AW   APB address
//    data_in    out  DW   APB write data
//    data_out   in   DW   APB read data
//    ready      in   1    APB slave ready
// ============================================================================
module apb_master_bridge #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
    output logic          sel,
    output logic          enable,
    output logic          w_en,
    output logic [AW-1:0] add,
    output logic [DW-1:0] data_in,
    input  logic [DW-1:0] data_out,
    input  logic          ready
);

    // Counter is at least one bit wide so TIMEOUT=0 still elaborates cleanly.
    localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_sel,       w_sel_nxt;
    logic                 r_enable,    w_enable_nxt;
    logic                 r_w_en,      w_w_en_nxt;
    logic [AW-1:0]        r_add,       w_add_nxt;
    logic [DW-1:0]        r_data_in,   w_data_in_nxt;
    logic                 r_rsp_valid, w_rsp_valid_nxt;
    logic                 r_rsp_err,   w_rsp_err_nxt;
    logic [DW-1:0]        r_rsp_rdata, w_rsp_rdata_nxt;
    logic [c_CNT_W-1:0]   r_cnt,       w_cnt_nxt;

    logic                 w_accept;
    logic                 w_timeout_hit;

    // Reset holds cmd_ready low even though the state already reads IDLE.
    assign cmd_ready = rst && (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // The counter holds the number of stalled ACCESS edges already seen, so
    // hitting TIMEOUT-1 on a stalled edge means this is the TIMEOUT-th one.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
            assign w_timeout_hit = (r_cnt == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_enable    <= 1'b0;
            r_w_en      <= 1'b0;
            r_add       <= '0;
            r_data_in   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_enable    <= w_enable_nxt;
            r_w_en      <= w_w_en_nxt;
            r_add       <= w_add_nxt;
            r_data_in   <= w_data_in_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        // Bus address/data/strobe hold their last value between transfers;
        // the response is a pulse so it defaults low every cycle.
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_enable_nxt    = r_enable;
        w_w_en_nxt      = r_w_en;
        w_add_nxt       = r_add;
        w_data_in_nxt   = r_data_in;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = S_SETUP;
                    w_sel_nxt     = 1'b1;
                    w_enable_nxt  = 1'b0;
                    w_w_en_nxt    = cmd_write;
                    w_add_nxt     = cmd_addr;
                    w_data_in_nxt = cmd_wdata;
                end
            end

            S_SETUP: begin
                w_state_nxt  = S_ACCESS;
                w_enable_nxt = 1'b1;
                w_cnt_nxt    = '0;
            end

            S_ACCESS: begin
                if (ready) begin
                    // Completion takes priority over a coincident timeout.
                    w_state_nxt     = S_IDLE;
                    w_sel_nxt       = 1'b0;
                    w_enable_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    if (!r_w_en) begin
                        w_rsp_rdata_nxt = data_out;
                    end
                end else if (w_timeout_hit) begin
                    w_state_nxt     = S_IDLE;
                    w_sel_nxt       = 1'b0;
                    w_enable_nxt    = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end else if (r_cnt != {c_CNT_W{1'b1}}) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_sel_nxt    = 1'b0;
                w_enable_nxt = 1'b0;
            end
        endcase
    end

    assign sel       = r_sel;
    assign enable    = r_enable;
    assign w_en      = r_w_en;
    assign add       = r_add;
    assign data_in   = r_data_in;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_master_bridge
//  Purpose  : Self-checking bench for apb_master_bridge. Two instances are
//             used: TIMEOUT=16 (a_*) and TIMEOUT=4 (b_*), sharing the command
//             payload, read data and reset, with private valid/ready lines.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_addr  = '0;
    logic [7:0] cmd_wdata = '0;
    logic [7:0] data_out  = '0;

    logic       a_cmd_valid = 1'b0, a_ready = 1'b0;
    logic       b_cmd_valid = 1'b0, b_ready = 1'b0;

    logic       a_cmd_ready, a_rsp_valid, a_rsp_err, a_sel, a_enable, a_w_en;
    logic [7:0] a_rsp_rdata, a_add, a_data_in;
    logic       b_cmd_ready, b_rsp_valid, b_rsp_err, b_sel, b_enable, b_w_en;
    logic [7:0] b_rsp_rdata, b_add, b_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_master_bridge #(.AW(8), .DW(8), .TIMEOUT(16)) u_dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err), .rsp_rdata(a_rsp_rdata),
        .sel(a_sel), .enable(a_enable), .w_en(a_w_en), .add(a_add),
        .data_in(a_data_in), .data_out(data_out), .ready(a_ready)
    );

    apb_master_bridge #(.AW(8), .DW(8), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err), .rsp_rdata(b_rsp_rdata),
        .sel(b_sel), .enable(b_enable), .w_en(b_w_en), .add(b_add),
        .data_in(b_data_in), .data_out(data_out), .ready(b_ready)
    );

    // Selected-instance view used by the generic transfer task.
    bit         tsel = 1'b0;
    logic       m_cmd_ready, m_rsp_valid, m_rsp_err, m_sel, m_enable, m_w_en;
    logic [7:0] m_rsp_rdata, m_add, m_data_in;
    assign m_cmd_ready = tsel ? b_cmd_ready : a_cmd_ready;
    assign m_rsp_valid = tsel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_err   = tsel ? b_rsp_err   : a_rsp_err;
    assign m_rsp_rdata = tsel ? b_rsp_rdata : a_rsp_rdata;
    assign m_sel       = tsel ? b_sel       : a_sel;
    assign m_enable    = tsel ? b_enable    : a_enable;
    assign m_w_en      = tsel ? b_w_en      : a_w_en;
    assign m_add       = tsel ? b_add       : a_add;
    assign m_data_in   = tsel ? b_data_in   : a_data_in;

    // Reference state: last response data per instance.
    logic [7:0] model_rd [2];

    typedef struct {
        bit         dut_b;
        bit         wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] dout;
        int         waits;
        int         exp_acc;
        bit         exp_err;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(bit b, bit wr, logic [7:0] a, logic [7:0] wd,
                                logic [7:0] dout, int waits, int acc, bit err,
                                logic [7:0] rd);
        vec_t v;
        v.dut_b = b; v.wr = wr; v.addr = a; v.wdata = wd; v.dout = dout;
        v.waits = waits; v.exp_acc = acc; v.exp_err = err; v.exp_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: a transfer lasts until the first ready or
    // until TIMEOUT stalled ACCESS cycles, whichever comes first.
    function automatic void model_xfer(input int to, input bit wr, input logic [7:0] dout,
                                       input int waits, inout logic [7:0] rd,
                                       output int acc, output bit err);
        if (to != 0 && waits >= to) begin
            acc = to; err = 1'b1; rd = 8'h00;
        end else begin
            acc = waits + 1; err = 1'b0;
            if (!wr) rd = dout;
        end
    endfunction

    task automatic set_valid(input bit v);
        if (tsel) b_cmd_valid = v; else a_cmd_valid = v;
    endtask

    task automatic set_ready(input bit r);
        if (tsel) b_ready = r; else a_ready = r;
    endtask

    // Runs one transfer on the selected instance from IDLE and checks the
    // whole bus waveform plus the response. Called at posedge+1.
    task automatic run_xfer(input bit b, input bit wr, input logic [7:0] addr,
                            input logic [7:0] wdata, input logic [7:0] dout,
                            input int waits, input int exp_acc, input bit exp_err,
                            input logic [7:0] exp_rd, input string name);
        int acc;
        tsel = b;
        #0;
        chk({name, ".cmd_ready_idle"}, m_cmd_ready, 1);
        cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; data_out = dout;
        set_valid(1'b1);
        set_ready(1'b0);
        @(posedge clk); #1;
        // SETUP: scramble the command port to prove it is ignored.
        set_valid(1'b0);
        cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        chk({name, ".setup_sel"},    m_sel, 1);
        chk({name, ".setup_enable"}, m_enable, 0);
        chk({name, ".setup_add"},    m_add, addr);
        chk({name, ".setup_wen"},    m_w_en, wr);
        chk({name, ".setup_ready"},  m_cmd_ready, 0);
        @(posedge clk); #1;
        acc = 0;
        while (m_enable === 1'b1 && acc < 64) begin
            acc++;
            if (m_sel !== 1'b1 || m_add !== addr || m_data_in !== wdata ||
                m_w_en !== wr || m_rsp_valid !== 1'b0) begin
                chk({name, ".access_bus"}, {m_sel, m_w_en, m_rsp_valid, m_add, m_data_in},
                    {1'b1, wr, 1'b0, addr, wdata});
            end
            set_ready(acc > waits);
            @(posedge clk); #1;
        end
        set_ready(1'b0);
        chk({name, ".access_cycles"}, acc, exp_acc);
        chk({name, ".rsp_valid"},     m_rsp_valid, 1);
        chk({name, ".rsp_err"},       m_rsp_err, exp_err);
        chk({name, ".rsp_rdata"},     m_rsp_rdata, exp_rd);
        chk({name, ".rsp_sel_en"},    {m_sel, m_enable}, 0);
        chk({name, ".held_bus"},      {m_w_en, m_add, m_data_in}, {wr, addr, wdata});
        @(posedge clk); #1;
        chk({name, ".rsp_pulse"},     {m_rsp_valid, m_rsp_err}, 0);
    endtask

    initial begin : main
        int acc;
        bit err;
        logic [7:0] st_addr, st_wdata;

        // --- reset state ---------------------------------------------------
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", {a_cmd_ready, b_cmd_ready}, 0);
        chk("reset_bus_a", {a_sel, a_enable, a_w_en, a_add, a_data_in}, 0);
        chk("reset_rsp_a", {a_rsp_valid, a_rsp_err, a_rsp_rdata}, 0);
        chk("reset_bus_b", {b_sel, b_enable, b_rsp_valid, b_rsp_rdata}, 0);
        rst = 1'b1;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        @(posedge clk); #1;

        // --- directed vectors ----------------------------------------------
        vecs[0] = mk(0, 1, 8'h3C, 8'hA5, 8'h00,  0,  1, 0, 8'h00);
        vecs[1] = mk(0, 0, 8'h10, 8'h00, 8'h5A,  2,  3, 0, 8'h5A);
        vecs[2] = mk(0, 0, 8'h44, 8'h00, 8'h99, 30, 16, 1, 8'h00);
        vecs[3] = mk(0, 1, 8'h01, 8'h11, 8'hEE,  1,  2, 0, 8'h00);
        vecs[4] = mk(1, 0, 8'h20, 8'h00, 8'h77,  3,  4, 0, 8'h77);
        vecs[5] = mk(1, 0, 8'h21, 8'h00, 8'h66,  4,  4, 1, 8'h00);
        vecs[6] = mk(1, 0, 8'h22, 8'h00, 8'hC3,  0,  1, 0, 8'hC3);
        for (int i = 0; i < 7; i++) begin
            run_xfer(vecs[i].dut_b, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].dout,
                     vecs[i].waits, vecs[i].exp_acc, vecs[i].exp_err, vecs[i].exp_rd,
                     $sformatf("vec%0d", i));
            model_rd[vecs[i].dut_b] = vecs[i].exp_rd;
        end

        // --- back-to-back with cmd_valid held high --------------------------
        tsel = 1'b0;
        a_ready = 1'b1;
        cmd_write = 1'b1;
        a_cmd_valid = 1'b1;
        st_addr = 8'h00; st_wdata = 8'h00;
        for (int c = 0; c < 12; c++) begin
            cmd_addr  = (c % 2 == 0) ? 8'h01 : 8'h02;
            cmd_wdata = 8'(8'h30 + c);
            #0;
            chk($sformatf("b2b.cmd_ready%0d", c), a_cmd_ready, (c % 3 == 0));
            chk($sformatf("b2b.rsp_valid%0d", c), a_rsp_valid, (c % 3 == 0 && c > 0));
            if (c % 3 == 0) begin
                st_addr = cmd_addr; st_wdata = cmd_wdata;
            end else begin
                chk($sformatf("b2b.add%0d", c), {a_add, a_data_in}, {st_addr, st_wdata});
            end
            @(posedge clk); #1;
        end
        a_cmd_valid = 1'b0;
        a_ready = 1'b0;
        chk("b2b.last_rsp", {a_rsp_valid, a_rsp_err}, 2'b10);
        @(posedge clk); #1;

        // --- reset during ACCESS -------------------------------------------
        tsel = 1'b0;
        cmd_write = 1'b0; cmd_addr = 8'h55; a_ready = 1'b0;
        a_cmd_valid = 1'b1;
        @(posedge clk); #1;
        a_cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.in_access", a_enable, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid.async_bus", {a_sel, a_enable, a_rsp_valid, a_cmd_ready}, 0);
        chk("rstmid.add_cleared", a_add, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;
        @(posedge clk); #1;
        chk("rstmid.no_rsp", {a_rsp_valid, a_sel}, 0);
        run_xfer(0, 1, 8'hFF, 8'h3E, 8'h12, 0, 1, 0, 8'h00, "post_rst_wr");

        // --- randomized transfers against the model --------------------------
        for (int i = 0; i < 24; i++) begin
            bit         b;
            bit         wr;
            logic [7:0] a, wd, d;
            int         w;
            logic [7:0] rd;
            b  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = 8'($urandom);
            wd = 8'($urandom);
            d  = 8'($urandom);
            w  = b ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 20));
            rd = model_rd[b];
            model_xfer(b ? 4 : 16, wr, d, w, rd, acc, err);
            run_xfer(b, wr, a, wd, d, w, acc, err, rd, $sformatf("rnd%0d", i));
            model_rd[b] = rd;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
